// File: rtl/seg7_scan_driver_pkg.sv
// seg7 scan driver shared types
// state enum, glyph table, one-hot check
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE,
    FAULT
  } state_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic is_onehot(
    input logic [3:0] p
  );
    return (p != 4'd0) &&
           ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7 scan driver signal bundle
// phase/value controls in, anodes/segments out
interface seg7_scan_driver_if;

  logic [0:3]  phase;
  logic [15:0] value;
  logic        load;
  logic        lzb_en;
  logic        err_clr;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        err;

  modport master (
    output phase,
    output value,
    output load,
    output lzb_en,
    output err_clr,
    input  an,
    input  seg,
    input  err
  );

  modport slave (
    input  phase,
    input  value,
    input  load,
    input  lzb_en,
    input  err_clr,
    output an,
    output seg,
    output err
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex nibble to seven-segment glyph
// active-high {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-seg driver
// blanks on phase change, frame-aligned update
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int BLANK_CYCLES   = 2,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam logic [3:0] BLANK_INIT =
    4'(BLANK_CYCLES - 1);
  localparam logic [3:0] AN_OFF =
    AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:3]  phase_q, phase_d;
  logic [15:0] staging_q, staging_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        err_q, err_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        phase_ok;
  logic        phase_chg;
  logic        enter_blank;
  logic        commit;
  logic [1:0]  dig;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic [3:0]  lz;
  logic [3:0]  an_on;
  logic        dig_blank;

  assign phase_d   = bus.phase;
  assign phase_ok  = is_onehot(bus.phase);
  assign phase_chg = (bus.phase != phase_q);

  // next state and blank counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!phase_ok) begin
      state_d = FAULT;
    end else if (phase_chg) begin
      state_d = BLANK;
      cnt_d   = BLANK_INIT;
    end else begin
      unique case (state_q)
        IDLE, FAULT: begin
          state_d = BLANK;
          cnt_d   = BLANK_INIT;
        end
        BLANK: begin
          if (cnt_q == 4'd0) begin
            state_d = DRIVE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DRIVE: state_d = DRIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign enter_blank = (state_d == BLANK) &&
    ((state_q != BLANK) || phase_chg);
  assign commit = enter_blank &&
    bus.phase[0] && pending_q;

  // staging/shadow value capture
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      staging_d = bus.value;
      pending_d = 1'b1;
    end
  end

  // sticky error, set beats clear
  always_comb begin
    err_d = err_q;
    if (state_d == FAULT) begin
      err_d = 1'b1;
    end else if (bus.err_clr &&
                 state_q != FAULT) begin
      err_d = 1'b0;
    end
  end

  assign dig = {phase_q[2] | phase_q[3],
                phase_q[1] | phase_q[3]};
  assign nib = shadow_q[{dig, 2'b00} +: 4];

  assign lz[3] = (shadow_q[15:12] == 4'd0);
  assign lz[2] = lz[3] &&
                 (shadow_q[11:8] == 4'd0);
  assign lz[1] = lz[2] &&
                 (shadow_q[7:4] == 4'd0);
  assign lz[0] = 1'b0;

  assign dig_blank = bus.lzb_en && lz[dig];

  hex_to_seg7 u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  // one-hot phase to per-anode enable
  always_comb begin
    an_on = 4'd0;
    for (int i = 0; i < 4; i++) begin
      an_on[i] = phase_q[i];
    end
  end

  // registered anode/segment outputs
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_q == DRIVE) begin
      an_d = AN_ACTIVE_LOW ? ~an_on : an_on;
      if (!dig_blank) begin
        seg_d = SEG_ACTIVE_LOW ? ~glyph : glyph;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      phase_q   <= 4'd0;
      staging_q <= 16'd0;
      shadow_q  <= 16'd0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// seg7_scan_driver directed bench
// hand-computed digit/segment expectations
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .BLANK_CYCLES   (2),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    bus.phase   = 4'b1000;
    bus.value   = 16'h0000;
    bus.load    = 1'b0;
    bus.lzb_en  = 1'b0;
    bus.err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset an=%h seg=%h err=%b want f/7f/0",
               bus.an, bus.seg, bus.err);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [0:3] ph;
    logic [3:0] an_e;
    int         dg [7] = '{1, 2, 3, 0, 1, 2, 3};
    logic [6:0] g  [7] = '{7'h3F, 7'h3F, 7'h3F,
                           7'h66, 7'h4F, 7'h5B, 7'h06};
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int s = 0; s < 7; s++) begin
      ph = 4'b0000;
      ph[dg[s]] = 1'b1;
      bus.phase = ph;
      an_e = 4'hF;
      an_e[dg[s]] = 1'b0;
      tick();
      for (int k = 1; k < 8; k++) begin
        tick();
        checks++;
        if (k < 3) begin
          if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
            errors++;
            $display("FAIL scan_blank s%0d k%0d an=%h seg=%h want f/7f",
                     s, k, bus.an, bus.seg);
          end
        end else if (bus.an !== an_e ||
                     bus.seg !== ~g[s]) begin
          errors++;
          $display("FAIL scan_drive s%0d k%0d an=%h seg=%h want %h/%h",
                   s, k, bus.an, bus.seg, an_e, ~g[s]);
        end
      end
    end
  endtask

  task automatic test_tear();
    logic [0:3]  ph;
    logic [3:0]  an_e;
    logic [6:0]  g  [8] = '{7'h66, 7'h4F, 7'h5B, 7'h06,
                            7'h5E, 7'h39, 7'h7C, 7'h77};
    logic [15:0] v  [8] = '{16'h0, 16'h5555, 16'hABCD,
                            16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int s = 0; s < 8; s++) begin
      ph = 4'b0000;
      ph[s % 4] = 1'b1;
      bus.phase = ph;
      an_e = 4'hF;
      an_e[s % 4] = 1'b0;
      if (s == 1 || s == 2) begin
        bus.value = v[s];
        bus.load  = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      for (int k = 1; k < 8; k++) begin
        tick();
        if (k >= 3) begin
          checks++;
          if (bus.an !== an_e || bus.seg !== ~g[s]) begin
            errors++;
            $display("FAIL tear s%0d k%0d an=%h seg=%h want %h/%h",
                     s, k, bus.an, bus.seg, an_e, ~g[s]);
          end
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [0:3] ph;
    logic [3:0] an_e;
    logic [6:0] sg [8] = '{7'h40, 7'h78, 7'h7F, 7'h7F,
                           7'h40, 7'h78, 7'h40, 7'h40};
    bus.value = 16'h0070;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int s = 0; s < 8; s++) begin
      ph = 4'b0000;
      ph[s % 4] = 1'b1;
      bus.phase  = ph;
      bus.lzb_en = (s < 4);
      an_e = 4'hF;
      an_e[s % 4] = 1'b0;
      tick();
      for (int k = 1; k < 8; k++) begin
        tick();
        if (k >= 3) begin
          checks++;
          if (bus.an !== an_e || bus.seg !== sg[s]) begin
            errors++;
            $display("FAIL lzb s%0d k%0d an=%h seg=%h want %h/%h",
                     s, k, bus.an, bus.seg, an_e, sg[s]);
          end
        end
      end
    end
    bus.lzb_en = 1'b0;
  endtask

  task automatic test_fault();
    bus.phase = 4'b0110;
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL fault_err err=%b want 1", bus.err);
    end
    tick();
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      errors++;
      $display("FAIL fault_off an=%h seg=%h want f/7f",
               bus.an, bus.seg);
    end
    bus.err_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.err !== 1'b1 || bus.an !== 4'hF) begin
        errors++;
        $display("FAIL fault_hold k%0d err=%b an=%h want 1/f",
                 k, bus.err, bus.an);
      end
    end
    bus.err_clr = 1'b0;
    bus.phase = 4'b1000;
    tick();
    tick();
    checks++;
    if (bus.an !== 4'hF || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL fault_blank an=%h err=%b want f/1",
               bus.an, bus.err);
    end
    tick();
    tick();
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h40 ||
        bus.err !== 1'b1) begin
      errors++;
      $display("FAIL fault_drive an=%h seg=%h err=%b want e/40/1",
               bus.an, bus.seg, bus.err);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.an !== 4'b1110) begin
      errors++;
      $display("FAIL fault_clr err=%b an=%h want 0/e",
               bus.err, bus.an);
    end
  endtask

  task automatic test_back_to_back();
    bus.phase   = 4'b0000;
    bus.err_clr = 1'b1;
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL zero_setwins err=%b want 1", bus.err);
    end
    tick();
    checks++;
    if (bus.an !== 4'hF) begin
      errors++;
      $display("FAIL zero_off an=%h want f", bus.an);
    end
    bus.phase = 4'b0100;
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL zero_exit_err err=%b want 1", bus.err);
    end
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.an !== 4'hF) begin
      errors++;
      $display("FAIL zero_clr err=%b an=%h want 0/f",
               bus.err, bus.an);
    end
    tick();
    tick();
    checks++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h78) begin
      errors++;
      $display("FAIL zero_drive an=%h seg=%h want d/78",
               bus.an, bus.seg);
    end
    bus.phase = 4'b0010;
    tick();
    bus.phase = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
        errors++;
        $display("FAIL b2b_blank k%0d an=%h seg=%h want f/7f",
                 k, bus.an, bus.seg);
      end
    end
    tick();
    checks++;
    if (bus.an !== 4'b0111 || bus.seg !== 7'h40) begin
      errors++;
      $display("FAIL b2b_drive an=%h seg=%h want 7/40",
               bus.an, bus.seg);
    end
  endtask

  task automatic test_reset_mid();
    bus.phase = 4'b1100;
    tick();
    bus.phase = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (bus.an !== 4'b0111 || bus.seg !== 7'h40 ||
        bus.err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset an=%h seg=%h err=%b want 7/40/1",
               bus.an, bus.seg, bus.err);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset an=%h seg=%h err=%b want f/7f/0",
               bus.an, bus.seg, bus.err);
    end
    bus.phase = 4'b0100;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
        errors++;
        $display("FAIL post_reset_blank k%0d an=%h seg=%h want f/7f",
                 k, bus.an, bus.seg);
      end
    end
    tick();
    checks++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h40) begin
      errors++;
      $display("FAIL post_reset_drive an=%h seg=%h want d/40",
               bus.an, bus.seg);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_tear();
    test_lzb();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
